// File: rtl/program_mem_controller_if.sv
// Fetch-side and memory-side handshake bundle for program_mem_controller.
// The controller uses the master view; the fetch units and memory use the slave view.
interface program_mem_controller_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic                               mem_read_valid;
  logic [ADDR_BITS-1:0]               mem_read_address;
  logic                               mem_read_ready;
  logic [DATA_BITS-1:0]               mem_read_data;

  modport master (
    input  consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );

  modport slave (
    output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/program_mem_controller.sv
// Round-robin arbiter sharing one program-memory read port among NUM_CONSUMERS
// fetch units; one transaction in flight, all outputs straight from flops.
module program_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  program_mem_controller_if.master  bus
);
  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {IDLE, WAITING, RELAYING} state_t;

  state_t                                  state_q, state_d;
  logic [IW-1:0]                           sel_q, sel_d;
  logic [IW-1:0]                           last_q, last_d;
  logic                                    mem_valid_q, mem_valid_d;
  logic [ADDR_BITS-1:0]                    mem_addr_q, mem_addr_d;
  logic [NUM_CONSUMERS-1:0]                rdy_q, rdy_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q, data_d;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] req_addr;
  logic [IW-1:0]                           pick;
  logic                                    any_req;

  assign req_addr = bus.consumer_read_address;

  // Search starts one past the last grant and wraps, so every requester is reached.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      idx = (int'(last_q) + k) % NUM_CONSUMERS;
      if (!any_req && bus.consumer_read_valid[idx]) begin
        any_req = 1'b1;
        pick    = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    rdy_d       = rdy_q;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d       = pick;
          last_d      = pick;
          mem_valid_d = 1'b1;
          mem_addr_d  = req_addr[pick];
          state_d     = WAITING;
        end
      end
      WAITING: begin
        if (bus.mem_read_ready) begin
          data_d[sel_q] = bus.mem_read_data;
          rdy_d[sel_q]  = 1'b1;
          mem_valid_d   = 1'b0;
          state_d       = RELAYING;
        end
      end
      RELAYING: begin
        // Completion is held until the fetcher withdraws its request.
        if (!bus.consumer_read_valid[sel_q]) begin
          rdy_d[sel_q] = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      last_q      <= IW'(NUM_CONSUMERS - 1);
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      rdy_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      rdy_q       <= rdy_d;
      data_q      <= data_d;
    end
  end

  assign bus.mem_read_valid      = mem_valid_q;
  assign bus.mem_read_address    = mem_addr_q;
  assign bus.consumer_read_ready = rdy_q;
  assign bus.consumer_read_data  = data_q;
endmodule

// File: tb/tb_program_mem_controller.sv
// Directed bench for program_mem_controller: transaction-level model compared
// every cycle, plus literal expectations for each scenario.
module tb_program_mem_controller;
  localparam int N = 4, A = 8, D = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  program_mem_controller_if #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N)) bus();
  program_mem_controller #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [N-1:0]        cvalid;
  logic [N-1:0][A-1:0] caddr;
  logic                mrdy;
  logic [D-1:0]        mdata;
  assign bus.consumer_read_valid   = cvalid;
  assign bus.consumer_read_address = caddr;
  assign bus.mem_read_ready        = mrdy;
  assign bus.mem_read_data         = mdata;

  int checks = 0, errors = 0;
  logic [D-1:0] mem_tbl [256];
  int mem_wait = 0;
  bit force_ready = 1'b0;
  bit [N-1:0] auto_drop = '0;
  logic [A-1:0] grants [$];
  bit pmv = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Memory: answers after mem_wait idle cycles; force_ready drives a stray ready.
  initial begin
    int cnt;
    cnt = 0; mrdy = 1'b0; mdata = '0;
    forever begin
      @(posedge clk); #2;
      if (bus.mem_read_valid && !reset) begin
        if (cnt >= mem_wait) begin
          mrdy = 1'b1; mdata = mem_tbl[bus.mem_read_address]; cnt = 0;
        end else begin
          mrdy = 1'b0; cnt++;
        end
      end else begin
        mrdy = force_ready; mdata = 16'hDEAD; cnt = 0;
      end
    end
  end

  // Fetchers flagged in auto_drop withdraw as soon as they see their ready.
  initial forever begin
    @(posedge clk); #2;
    for (int i = 0; i < N; i++)
      if (auto_drop[i] && bus.consumer_read_ready[i]) cvalid[i] = 1'b0;
  end

  // Transaction-level model.
  int           m_srv;
  bit           m_pend;
  int           m_last;
  bit [N-1:0]   e_rdy;
  logic [D-1:0] e_data [N];
  bit           e_mv;
  logic [A-1:0] e_ma;

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_srv <= -1; m_pend <= 1'b0; m_last <= N - 1;
      e_rdy <= '0; e_mv <= 1'b0; e_ma <= '0;
      for (int i = 0; i < N; i++) e_data[i] <= '0;
    end else if (m_srv < 0) begin
      if (rr_pick(m_last, cvalid) >= 0) begin
        m_srv  <= rr_pick(m_last, cvalid);
        m_last <= rr_pick(m_last, cvalid);
        m_pend <= 1'b1;
        e_mv   <= 1'b1;
        e_ma   <= caddr[rr_pick(m_last, cvalid)];
      end
    end else if (m_pend) begin
      if (mrdy === 1'b1) begin
        e_data[m_srv] <= mdata;
        e_rdy[m_srv]  <= 1'b1;
        e_mv          <= 1'b0;
        m_pend        <= 1'b0;
      end
    end else if (!cvalid[m_srv]) begin
      e_rdy[m_srv] <= 1'b0;
      m_srv        <= -1;
    end
  end

  always @(negedge clk) begin
    chk("mem_read_valid", 64'(bus.mem_read_valid), 64'(e_mv));
    chk("mem_read_address", 64'(bus.mem_read_address), 64'(e_ma));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("ready[%0d]", i), 64'(bus.consumer_read_ready[i]), 64'(e_rdy[i]));
      chk($sformatf("data[%0d]", i), 64'(bus.consumer_read_data[i*D +: D]), 64'(e_data[i]));
    end
    chk("onehot_ready", 64'($countones(bus.consumer_read_ready) <= 1), 64'd1);
    if (bus.mem_read_valid && !pmv) grants.push_back(bus.mem_read_address);
    pmv <= bus.mem_read_valid;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic wait_mv(input string nm);
    int t;
    t = 0;
    while (bus.mem_read_valid !== 1'b1 && t < 50) begin cyc(1); t++; end
    chk({nm, "_mv_timeout"}, 64'(bus.mem_read_valid), 64'd1);
  endtask

  task automatic wait_rdy(input int i, input string nm);
    int t;
    t = 0;
    while (bus.consumer_read_ready[i] !== 1'b1 && t < 50) begin cyc(1); t++; end
    chk({nm, "_rdy_timeout"}, 64'(bus.consumer_read_ready[i]), 64'd1);
  endtask

  task automatic wait_all_drop(input string nm);
    int t;
    t = 0;
    while (cvalid != '0 && t < 100) begin cyc(1); t++; end
    chk({nm, "_drain_timeout"}, 64'(cvalid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) mem_tbl[a] = 16'h5A00 | 16'(a);
    cvalid = '0; caddr = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_mem_valid", 64'(bus.mem_read_valid), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_read_address), 64'd0);
    chk("rst_ready", 64'(bus.consumer_read_ready), 64'd0);
    chk("rst_data", 64'(bus.consumer_read_data), 64'd0);
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Single request, two memory wait cycles, ready held while valid stays up.
    mem_tbl[8'h1A] = 16'hBEEF; mem_wait = 2; caddr[2] = 8'h1A; cvalid[2] = 1'b1;
    wait_mv("t1");
    chk("t1_addr", 64'(bus.mem_read_address), 64'h1A);
    wait_rdy(2, "t1");
    chk("t1_data", 64'(bus.consumer_read_data[2*D +: D]), 64'hBEEF);
    chk("t1_model_data", 64'(e_data[2]), 64'hBEEF);
    cyc(2);
    chk("t1_hold", 64'(bus.consumer_read_ready[2]), 64'd1);
    cvalid[2] = 1'b0;
    cyc(1);
    chk("t1_drop", 64'(bus.consumer_read_ready[2]), 64'd0);
    cyc(2);

    // Contention straight after reset: order 0,1,3, then a re-raised 0.
    reset = 1'b1; cyc(1); reset = 1'b0;
    grants.delete();
    mem_wait = 0; caddr[0] = 8'h00; caddr[1] = 8'h11; caddr[3] = 8'h33;
    auto_drop = 4'b1011; cvalid = 4'b1011;
    begin
      int t;
      t = 0;
      while (grants.size() < 2 && t < 100) begin cyc(1); t++; end
      cvalid[0] = 1'b1;
      t = 0;
      while (grants.size() < 4 && t < 100) begin cyc(1); t++; end
    end
    wait_all_drop("t2");
    cyc(3);
    chk("t2_grant_count", 64'(grants.size()), 64'd4);
    if (grants.size() >= 4) begin
      chk("t2_grant0", 64'(grants[0]), 64'h00);
      chk("t2_grant1", 64'(grants[1]), 64'h11);
      chk("t2_grant2", 64'(grants[2]), 64'h33);
      chk("t2_grant3", 64'(grants[3]), 64'h00);
    end

    // Address changes after grant are ignored.
    auto_drop = 4'b1000; mem_wait = 3; caddr[3] = 8'h10; cvalid[3] = 1'b1;
    wait_mv("t3");
    caddr[3] = 8'h20;
    repeat (3) begin
      cyc(1);
      chk("t3_mv_stable", 64'(bus.mem_read_valid), 64'd1);
      chk("t3_addr_stable", 64'(bus.mem_read_address), 64'h10);
    end
    wait_rdy(3, "t3");
    cyc(3);

    // Withdraw during WAITING: data still lands, ready lasts one cycle.
    auto_drop = '0; mem_tbl[8'h22] = 16'hC0DE; mem_wait = 2; caddr[2] = 8'h22; cvalid[2] = 1'b1;
    wait_mv("t4");
    cvalid[2] = 1'b0;
    wait_rdy(2, "t4");
    chk("t4_data", 64'(bus.consumer_read_data[2*D +: D]), 64'hC0DE);
    cyc(1);
    chk("t4_ready_clear", 64'(bus.consumer_read_ready[2]), 64'd0);
    cyc(2);

    // Held handshake on consumer 1, then consumer 0 served without touching slice 1.
    mem_tbl[8'h40] = 16'h1234; mem_wait = 0; caddr[1] = 8'h40; cvalid[1] = 1'b1;
    wait_rdy(1, "t5");
    repeat (4) begin
      chk("t5_hold_ready", 64'(bus.consumer_read_ready[1]), 64'd1);
      chk("t5_no_new_mv", 64'(bus.mem_read_valid), 64'd0);
      cyc(1);
    end
    cvalid[1] = 1'b0;
    cyc(1);
    chk("t5_ready_clear", 64'(bus.consumer_read_ready[1]), 64'd0);
    mem_tbl[8'h41] = 16'h5678; caddr[0] = 8'h41; auto_drop = 4'b0001; cvalid[0] = 1'b1;
    wait_rdy(0, "t5b");
    chk("t5_data0", 64'(bus.consumer_read_data[0*D +: D]), 64'h5678);
    chk("t5_data1_kept", 64'(bus.consumer_read_data[1*D +: D]), 64'h1234);
    chk("t5_single_ready", 64'($countones(bus.consumer_read_ready)), 64'd1);
    cyc(3);

    // Reset while waiting on memory; stale ready afterwards is ignored.
    auto_drop = '0; mem_wait = 10; caddr[1] = 8'h50; cvalid[1] = 1'b1;
    wait_mv("t6");
    cyc(1);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_mv", 64'(bus.mem_read_valid), 64'd0);
    chk("t6_async_addr", 64'(bus.mem_read_address), 64'd0);
    chk("t6_async_ready", 64'(bus.consumer_read_ready), 64'd0);
    chk("t6_async_data", 64'(bus.consumer_read_data), 64'd0);
    cvalid = '0;
    cyc(1);
    reset = 1'b0;
    force_ready = 1'b1;
    repeat (3) begin
      cyc(1);
      chk("t6_stale_ready", 64'(bus.consumer_read_ready), 64'd0);
      chk("t6_stale_mv", 64'(bus.mem_read_valid), 64'd0);
    end
    force_ready = 1'b0;
    cyc(1);

    // Clean restart: consumer 0 has priority over 2 again.
    grants.delete();
    mem_wait = 1; caddr[0] = 8'h60; caddr[2] = 8'h62; auto_drop = '1; cvalid = 4'b0101;
    wait_all_drop("t7");
    cyc(3);
    chk("t7_grant_count", 64'(grants.size()), 64'd2);
    if (grants.size() >= 2) begin
      chk("t7_first", 64'(grants[0]), 64'h60);
      chk("t7_second", 64'(grants[1]), 64'h62);
    end
    chk("t7_data0", 64'(bus.consumer_read_data[0*D +: D]), 64'h5A60);
    chk("t7_data2", 64'(bus.consumer_read_data[2*D +: D]), 64'h5A62);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
